regfile_wr: RTL and testbench
=============================

REGFILE_WR -- requirements
Module: regfile_wr

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of wr_data.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 wr_valid  input  1  write request present.
REQ-005 wr_ready  output  1  block can accept a request this cycle.
REQ-006 wr_addr  input  5  destination register index 0..31.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 wr_freeze  input  1  when high, the held write does not commit.
REQ-009 reg_flat  output  32*DATA_W  register k on bits [DATA_W*k+DATA_W-1 : DATA_W*k]; this bus feeds the 32:1 read multiplexers.
REQ-010 dec_onehot  output  32  registered one-hot decode of the most recently committed address.
REQ-011 commit_pulse  output  1  high for exactly one cycle per committed write.

Function
REQ-012 The block SHALL hold one write in a buffer, with states EMPTY and HELD.
REQ-013 A request SHALL be accepted on a rising edge where wr_valid and wr_ready are both high; wr_addr and wr_data are captured on that edge.
REQ-014 wr_ready SHALL be combinational: high when state is EMPTY, or when state is HELD and wr_freeze is low.
REQ-015 In HELD with wr_freeze low, the next edge SHALL commit the held write:
  - register[addr] <= data
  - dec_onehot <= 1 << addr
  - commit_pulse high for the following cycle
REQ-016 Transitions:
  - EMPTY->HELD on accept.
  - HELD->HELD on commit plus accept in the same cycle, or when frozen.
  - HELD->EMPTY on commit without accept.
REQ-017 Sustained throughput SHALL be one write per cycle while wr_freeze is low.
REQ-018 Latency: a write accepted at edge N becomes visible on reg_flat after edge N+1, provided wr_freeze is low in the cycle between those edges.
REQ-019 While wr_freeze is high, reg_flat, dec_onehot and the held entry SHALL NOT change, and commit_pulse SHALL be low.
  - If the state is EMPTY, one request may still be accepted.
  - If the state is HELD, no request is accepted.
REQ-020 Register 0 SHALL read as zero at all times. A write to address 0 is still accepted and committed (commit_pulse high, dec_onehot = 32'h1), but storage is unchanged.
REQ-021 Only the addressed register SHALL change on a commit; all other registers hold their values.
REQ-022 No read-during-write bypass: reg_flat SHALL reflect storage contents only.
REQ-023 wr_addr and wr_data SHALL be ignored in any cycle where no accept occurs.

Reset
REQ-024 While reset is high, the following SHALL be forced immediately, independent of clock:
  - all registers 0
  - state EMPTY
  - dec_onehot 0
  - commit_pulse 0
REQ-025 A write held when reset asserts SHALL be discarded and never committed.
REQ-026 After reset deasserts, wr_ready SHALL be high in the first cycle.

Structure
REQ-027 Shared package regfile_pkg SHALL hold:
  - NUM_REGS = 32
  - ADDR_W = 5
  - the EMPTY/HELD state enumeration
REQ-028 Address decoding SHALL be a separate sub-module, decoder5to32: 5-bit input, enable input, 32-bit one-hot output, all zeros when disabled.

Verification
REQ-029 Single write: after reset, write addr 5, data 32'hDEADBEEF → two edges later, reg_flat[191:160] = 32'hDEADBEEF, dec_onehot = 32'h20, one commit_pulse, all other registers 0.
REQ-030 Back-to-back writes: 32 consecutive cycles writing data = addr*32'h01010101 to addr = 0..31 → wr_ready high throughout, 32 commit_pulses, register 0 = 0, register 31 = 32'h1F1F1F1F.
REQ-031 Freeze: accept addr 3 data 32'h1, hold wr_freeze for 4 cycles with wr_valid high → wr_ready low, register 3 unchanged. On freeze release, commit occurs the next edge and the waiting request is accepted in the same cycle.
REQ-032 Register 0 protection: write 32'hFFFFFFFF to addr 0 → commit_pulse high, dec_onehot = 32'h1, reg_flat[31:0] = 0.
REQ-033 Reset mid-operation: accept addr 7 data 32'h55 and assert reset before the commit edge → register 7 = 0, no commit_pulse, wr_ready high after reset release.
REQ-034 Overwrite: write addr 9 with 32'hA, then 32'hB on the next cycle → register 9 = 32'hB, neighbouring registers 8 and 10 unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write path.
//   NUM_REGS   : number of architectural registers (32)
//   ADDR_W     : register index width (5)
//   wr_state_e : write-buffer occupancy (EMPTY / HELD)
//   onehot_of  : helper turning a register index into a one-hot vector
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } wr_state_e;

  // One-hot vector with only bit 'addr' set.
  function automatic logic [NUM_REGS-1:0] onehot_of(input logic [ADDR_W-1:0] addr);
    onehot_of = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/regfile_wr_if.sv
// regfile_wr_if: write-request channel into the register file.
//   wr_valid  : request present (master -> slave)
//   wr_ready  : slave can take a request this cycle (slave -> master)
//   wr_addr   : destination register index
//   wr_data   : write data
//   wr_freeze : stalls commit of the held write (master -> slave)
interface regfile_wr_if #(
  parameter int DATA_W = 32
) ();
  import regfile_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_freeze;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_freeze,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_freeze,
    output wr_ready
  );

endinterface

// File: rtl/regfile_wr_decoder5to32.sv
// decoder5to32: 5-bit index to 32-bit one-hot decoder.
//   addr   : register index
//   en     : decode enable
//   onehot : one-hot of addr when en is high, all zeros otherwise
module decoder5to32
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // Gated one-hot decode of the index.
  always_comb begin
    onehot = {NUM_REGS{1'b0}};
    if (en) begin
      onehot = onehot_of(addr);
    end else begin
      onehot = {NUM_REGS{1'b0}};
    end
  end

endmodule

// File: rtl/regfile_wr.sv
// regfile_wr: 32-entry register file write path with a one-deep write buffer.
//   clock        : rising-edge clock
//   reset        : asynchronous active-high reset
//   wr           : write channel (slave side of regfile_wr_if)
//   reg_flat     : all registers flattened, register k at [DATA_W*k +: DATA_W]
//   dec_onehot   : one-hot of the most recently committed address
//   commit_pulse : one-cycle pulse per committed write
// A request is captured into the buffer on accept and committed on the next
// edge unless wr_freeze is high. A commit and a new accept may share an edge,
// giving one write per cycle while unfrozen. Register 0 has no storage.
module regfile_wr
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  regfile_wr_if.slave                wr,
  output logic [NUM_REGS*DATA_W-1:0] reg_flat,
  output logic [NUM_REGS-1:0]        dec_onehot,
  output logic                       commit_pulse
);

  wr_state_e           state_r;
  logic [ADDR_W-1:0]   held_addr_r;
  logic [DATA_W-1:0]   held_data_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS-1:1];
  logic [NUM_REGS-1:0] dec_onehot_r;
  logic                commit_pulse_r;

  logic                ready_s;
  logic                commit_s;
  logic                accept_s;
  logic [NUM_REGS-1:0] dec_s;

  // Ready, commit and accept conditions for the current cycle.
  always_comb begin
    ready_s  = 1'b0;
    commit_s = 1'b0;
    if (state_r == HELD) begin
      commit_s = ~wr.wr_freeze;
      ready_s  = ~wr.wr_freeze;
    end else begin
      commit_s = 1'b0;
      ready_s  = 1'b1;
    end
    accept_s = wr.wr_valid & ready_s;
  end

  assign wr.wr_ready = ready_s;

  // Decode is enabled only on a commit, so dec_s doubles as the write strobe.
  decoder5to32 u_dec (
    .addr   (held_addr_r),
    .en     (commit_s),
    .onehot (dec_s)
  );

  // Buffer state machine, captured request, and commit status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= EMPTY;
      held_addr_r    <= {ADDR_W{1'b0}};
      held_data_r    <= {DATA_W{1'b0}};
      dec_onehot_r   <= {NUM_REGS{1'b0}};
      commit_pulse_r <= 1'b0;
    end else begin
      commit_pulse_r <= commit_s;
      if (commit_s) begin
        dec_onehot_r <= dec_s;
      end
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r     <= HELD;
            held_addr_r <= wr.wr_addr;
            held_data_r <= wr.wr_data;
          end
        end
        HELD: begin
          // An accept in HELD implies freeze is low, so a commit happens too.
          if (accept_s) begin
            state_r     <= HELD;
            held_addr_r <= wr.wr_addr;
            held_data_r <= wr.wr_data;
          end else if (commit_s) begin
            state_r <= EMPTY;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  // Register storage; only the strobed register takes the held data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        regs_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (dec_s[k]) begin
          regs_r[k] <= held_data_r;
        end
      end
    end
  end

  // Flatten storage onto the read bus; register 0 is hard-wired to zero.
  always_comb begin
    reg_flat = {(NUM_REGS*DATA_W){1'b0}};
    for (int k = 1; k < NUM_REGS; k++) begin
      reg_flat[k*DATA_W +: DATA_W] = regs_r[k];
    end
  end

  assign dec_onehot   = dec_onehot_r;
  assign commit_pulse = commit_pulse_r;

endmodule

// File: tb/tb_regfile_wr.sv
// tb_regfile_wr: directed bench for regfile_wr with a per-cycle reference model
// and hand-computed checkpoints.
module tb_regfile_wr;
  import regfile_pkg::*;

  localparam int DW = 32;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NUM_REGS*DW-1:0] reg_flat;
  logic [NUM_REGS-1:0]    dec_onehot;
  logic                   commit_pulse;

  regfile_wr_if #(.DATA_W(DW)) bus ();

  regfile_wr #(.DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr           (bus),
    .reg_flat     (reg_flat),
    .dec_onehot   (dec_onehot),
    .commit_pulse (commit_pulse)
  );

  always #5 clock = ~clock;

  int tests   = 0;
  int fails   = 0;
  int commits = 0;
  bit chk_en  = 1'b0;

  // Reference model: register array plus a pending-write queue of depth <= 1.
  logic [DW-1:0] m_regs [NUM_REGS];
  logic [31:0]   m_dec;
  logic          m_pulse;
  int            q_addr [$];
  logic [DW-1:0] q_data [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rg(input int k);
    return reg_flat[k*DW +: DW];
  endfunction

  // Model update: writes wait in the queue until an unfrozen edge retires them.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
      m_dec   = 32'h0;
      m_pulse = 1'b0;
      q_addr.delete();
      q_data.delete();
    end else begin
      bit frz;
      bit do_commit;
      bit do_acc;
      int a;
      frz       = (bus.wr_freeze === 1'b1);
      do_commit = (q_addr.size() > 0) && !frz;
      do_acc    = (bus.wr_valid === 1'b1) && ((q_addr.size() == 0) || !frz);
      m_pulse   = do_commit;
      if (do_commit) begin
        a = q_addr.pop_front();
        if (a != 0) m_regs[a] = q_data[0];
        void'(q_data.pop_front());
        m_dec = 32'd1 << a;
      end
      if (do_acc) begin
        q_addr.push_back(int'(bus.wr_addr));
        q_data.push_back(bus.wr_data);
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      int bad;
      bad = -1;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (reg_flat[k*DW +: DW] !== m_regs[k] && bad < 0) bad = k;
      end
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL reg_flat: reg %0d got %h expected %h at %0t",
                 bad, reg_flat[bad*DW +: DW], m_regs[bad], $time);
      end
      check("dec_onehot", dec_onehot, m_dec);
      check("commit_pulse", {31'd0, commit_pulse}, {31'd0, m_pulse});
      check("wr_ready", {31'd0, bus.wr_ready},
            {31'd0, (q_addr.size() == 0) || (bus.wr_freeze !== 1'b1)});
      if (commit_pulse === 1'b1) commits++;
    end
  end

  task automatic drive(input bit v, input int a, input logic [31:0] d, input bit f);
    bus.wr_valid  = v;
    bus.wr_addr   = a[4:0];
    bus.wr_data   = d;
    bus.wr_freeze = f;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NUM_REGS*DW-1:0] tmp;
    int c0;
    reset = 1'b1;
    drive(0, 0, 32'h0, 0);
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, bus.wr_ready}, 32'h1);

    // Single write to register 5; idle cycle carries junk that must be ignored.
    drive(1, 5, 32'hDEADBEEF, 0);
    step();
    drive(0, 13, 32'h12345678, 0);
    step();
    check("single_data", rg(5), 32'hDEADBEEF);
    check("single_dec", dec_onehot, 32'h20);
    check("single_pulse", {31'd0, commit_pulse}, 32'h1);
    tmp = reg_flat;
    tmp[191:160] = 32'h0;
    check("single_others_zero", {31'd0, (tmp == '0)}, 32'h1);
    step();
    check("single_pulse_end", {31'd0, commit_pulse}, 32'h0);

    // Back-to-back writes to every register.
    c0 = commits;
    for (int a = 0; a < NUM_REGS; a++) begin
      drive(1, a, 32'(a) * 32'h01010101, 0);
      #1;
      check("b2b_ready", {31'd0, bus.wr_ready}, 32'h1);
      step();
    end
    drive(0, 0, 32'h0, 0);
    step();
    step();
    check("b2b_commits", commits - c0, 32'd32);
    check("b2b_reg0", rg(0), 32'h0);
    check("b2b_reg16", rg(16), 32'h10101010);
    check("b2b_reg31", rg(31), 32'h1F1F1F1F);

    // Freeze while HELD: nothing moves, then commit and accept together.
    drive(1, 3, 32'h1, 0);
    step();
    drive(1, 4, 32'h44, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("frz_ready", {31'd0, bus.wr_ready}, 32'h0);
      step();
      check("frz_reg3", rg(3), 32'h03030303);
      check("frz_pulse", {31'd0, commit_pulse}, 32'h0);
    end
    drive(1, 4, 32'h44, 0);
    #1;
    check("frz_release_ready", {31'd0, bus.wr_ready}, 32'h1);
    step();
    check("frz_commit_reg3", rg(3), 32'h1);
    check("frz_commit_dec", dec_onehot, 32'h8);
    drive(0, 0, 32'h0, 0);
    step();
    check("frz_next_reg4", rg(4), 32'h44);
    check("frz_next_dec", dec_onehot, 32'h10);
    step();

    // Register 0 protection.
    drive(1, 0, 32'hFFFFFFFF, 0);
    step();
    drive(0, 0, 32'h0, 0);
    step();
    check("r0_pulse", {31'd0, commit_pulse}, 32'h1);
    check("r0_dec", dec_onehot, 32'h1);
    check("r0_data", rg(0), 32'h0);
    step();

    // Reset while a write is held: it must never commit.
    drive(1, 7, 32'h55, 0);
    step();
    drive(0, 0, 32'h0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_reg7", rg(7), 32'h0);
    check("rst_dec", dec_onehot, 32'h0);
    check("rst_pulse", {31'd0, commit_pulse}, 32'h0);
    c0 = commits;
    step();
    reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.wr_ready}, 32'h1);
    step();
    step();
    check("rst_no_commit", commits - c0, 32'd0);
    check("rst_reg7_after", rg(7), 32'h0);

    // Freeze while EMPTY still accepts one request, then blocks further ones.
    drive(1, 2, 32'h22, 1);
    #1;
    check("frz_empty_ready", {31'd0, bus.wr_ready}, 32'h1);
    step();
    drive(0, 0, 32'h0, 1);
    #1;
    check("frz_held_ready", {31'd0, bus.wr_ready}, 32'h0);
    step();
    check("frz_empty_reg2", rg(2), 32'h0);
    drive(0, 0, 32'h0, 0);
    step();
    check("frz_empty_commit", rg(2), 32'h22);
    check("frz_empty_dec", dec_onehot, 32'h4);

    // Overwrite of the same register on consecutive cycles.
    drive(1, 9, 32'hA, 0);
    step();
    drive(1, 9, 32'hB, 0);
    step();
    check("ovw_first", rg(9), 32'hA);
    drive(0, 0, 32'h0, 0);
    step();
    check("ovw_reg9", rg(9), 32'hB);
    check("ovw_reg8", rg(8), 32'h0);
    check("ovw_reg10", rg(10), 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
